// File: rtl/dadda_pkg.sv
// Shared definitions for the Dadda multiplier product path: default product
// width, count-width helper and the accumulator state encoding.
package dadda_pkg;

    localparam int DEFAULT_PROD_W = 16;

    function automatic int cnt_w(input int max_terms);
        return $clog2(max_terms) + 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/dadda_sat_adder.sv
// Combinational unsigned add of a product onto the running sum, one bit wider
// than the accumulator so the carry-out flags overflow; clamps when SATURATE.
module dadda_sat_adder #(
    parameter int ACC_W    = 24,
    parameter int PROD_W   = 16,
    parameter int SATURATE = 1
) (
    input  logic [ACC_W-1:0]  base,
    input  logic [PROD_W-1:0] addend,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [ACC_W:0] full;

    assign full = {1'b0, base} + (ACC_W + 1)'(addend);
    assign ovf  = full[ACC_W];

    always_comb begin
        sum = full[ACC_W-1:0];
        if (ovf && (SATURATE != 0)) begin
            sum = '1;
        end
    end

endmodule

// File: rtl/dadda_product_accumulator.sv
// Accumulates a stream of unsigned multiplier products into one dot-product
// per packet and presents the registered result with a term count and overflow flag.
module dadda_product_accumulator #(
    parameter int PROD_W    = dadda_pkg::DEFAULT_PROD_W,
    parameter int ACC_W     = 24,
    parameter int MAX_TERMS = 256,
    parameter int SATURATE  = 1,
    localparam int CNT_W    = dadda_pkg::cnt_w(MAX_TERMS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_overflow
);

    import dadda_pkg::*;

    state_t             state;
    state_t             state_next;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   count;
    logic               ovf_reg;

    logic               accept;
    logic               new_pkt;
    logic               pkt_end;
    logic [ACC_W-1:0]   add_base;
    logic [ACC_W-1:0]   add_sum;
    logic               add_ovf;
    logic [CNT_W-1:0]   count_next;
    logic               ovf_next;

    // HOLD only blocks input while the result is still waiting downstream.
    assign in_ready   = (state != HOLD) || out_ready;
    assign out_valid  = (state == HOLD);
    assign accept     = in_valid && in_ready;
    assign new_pkt    = (state != ACCUM);
    assign add_base   = new_pkt ? '0 : acc;
    assign count_next = new_pkt ? CNT_W'(1) : count + 1'b1;
    assign ovf_next   = (new_pkt ? 1'b0 : ovf_reg) | add_ovf;
    assign pkt_end    = in_last || (count_next == CNT_W'(MAX_TERMS));

    dadda_sat_adder #(
        .ACC_W    (ACC_W),
        .PROD_W   (PROD_W),
        .SATURATE (SATURATE)
    ) u_adder (
        .base   (add_base),
        .addend (in_product),
        .sum    (add_sum),
        .ovf    (add_ovf)
    );

    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = pkt_end ? HOLD : ACCUM;
        end else if ((state == HOLD) && out_ready) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            count        <= '0;
            ovf_reg      <= 1'b0;
            out_sum      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                acc     <= add_sum;
                count   <= count_next;
                ovf_reg <= ovf_next;
                if (pkt_end) begin
                    out_sum      <= add_sum;
                    out_count    <= count_next;
                    out_overflow <= ovf_next;
                end
            end
        end
    end

endmodule

// File: doc/dadda_product_accumulator.md
Name: dadda_product_accumulator

Overview:
- Downstream consumer of the 8x8 Dadda multiplier's 16-bit unsigned product.
- Accumulates a stream of products into a wider register, one dot-product per packet, with valid/ready handshakes on both sides.
- The packet ends on in_last, or when MAX_TERMS products have been accepted.
- The registered accumulated sum is presented downstream together with a term count and an overflow flag.

Parameters:
- PROD_W, 16, product width; must match the multiplier's Result width.
- ACC_W, 24, accumulator width; must be >= PROD_W.
- MAX_TERMS, 256, maximum products per packet; reaching it forces packet end.
- SATURATE, 1, 1 = clamp the sum at 2^ACC_W-1 on overflow; 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  product beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_product  in  PROD_W  unsigned product from the multiplier
- in_last  in  1  beat is the final term of the packet
- out_valid  out  1  accumulated result valid
- out_ready  in  1  downstream accepts the result
- out_sum  out  ACC_W  accumulated sum
- out_count  out  $clog2(MAX_TERMS)+1  number of terms in the packet
- out_overflow  out  1  the packet overflowed ACC_W at least once

Behaviour:
- Reset: the synchronous rst has priority over all other inputs and is applied at any point, including mid-packet or in HOLD. After reset:
  - out_valid=0, out_sum=0, out_count=0, out_overflow=0.
  - The internal accumulator, count and overflow register are 0; state=IDLE.
  - in_ready=1 in the cycle after reset deasserts.
  - A partial packet is discarded.
- States: IDLE (no terms yet), ACCUM (>=1 term accepted, no last yet), HOLD (result presented).
- Beat accept: in_valid & in_ready.
- in_ready:
  - 1 in IDLE and ACCUM.
  - In HOLD, in_ready = out_ready: a new packet may start in the same cycle the result is taken.
- Accumulate, on accept:
  - next_sum = (state==IDLE or HOLD ? 0 : acc) + zero-extended in_product, computed at ACC_W+1 bits.
  - If bit ACC_W is set: the overflow register sets (sticky for the packet). acc takes 2^ACC_W-1 if SATURATE, otherwise the low ACC_W bits.
  - Once saturated, further adds keep acc at the maximum.
  - count = (new packet ? 1 : count+1).
- Packet end, on an accepted beat with in_last=1 or count+1==MAX_TERMS:
  - out_sum, out_count and out_overflow load the final values.
  - out_valid=1 from the next cycle; state goes to HOLD.
  - Latency from the last beat accepted to out_valid is 1 cycle.
- Single-term packet: in_last on the first beat goes IDLE->HOLD directly.
- HOLD:
  - out_* are stable while out_valid & !out_ready.
  - On out_ready with no accepted beat: out_valid=0, state goes to IDLE. out_sum/out_count/out_overflow keep their values but are don't-care.
  - On out_ready with an accepted beat, the result is retired and the beat starts a new packet.
    - Non-last beat: state goes to ACCUM, count=1, acc=in_product, overflow clears.
    - Last beat: state stays HOLD with out_valid held at 1 and the new result loaded. This gives back-to-back single-term packets at 1 per cycle.
- IDLE and ACCUM: a cycle with in_valid=0 holds all state. No timeout.
- in_product is never sign-extended; all arithmetic is unsigned.

Decomposition:
- Shared package dadda_pkg holds:
  - PROD_W=16 default.
  - The function cnt_w(MAX_TERMS)=$clog2(MAX_TERMS)+1.
  - The state enum {IDLE, ACCUM, HOLD}.
- One natural sub-module: dadda_sat_adder. It is combinational, computes ACC_W+1-bit add plus clamp, and outputs sum and ovf. The FSM, counter and output registers stay in the top.

Test Plan:
- Four beats of 65025 (255x255), last on the 4th, out_ready=1 → one cycle after the 4th beat: out_valid=1, out_sum=260100, out_count=4, out_overflow=0.
- ACC_W=18, SATURATE=1, five beats of 65025 → out_sum=262143, out_overflow=1, out_count=5. The same run with SATURATE=0 → out_sum=325125-262144=62981, out_overflow=1.
- MAX_TERMS=4, in_last held 0, beats 1,2,3,4 → forced end: out_sum=10, out_count=4. A 5th beat of 7 starts a new packet with sum 7.
- out_ready=0 for 5 cycles in HOLD with in_valid=1 → in_ready=0 and out_sum stable. Then out_ready=1 with the beat 100, in_last=1 → the old result is retired and out_valid stays 1 with out_sum=100, out_count=1.
- rst asserted after two beats (3, 5) of an unterminated packet, then a beat of 9 with last → out_sum=9, out_count=1, out_overflow=0.
- Random bursts of 1..MAX_TERMS products with random in_valid/out_ready gaps → sums match a scoreboard, with no lost or duplicated packets.
